// File: rtl/config_loader_pkg.sv
// -----------------------------------------------------------------------------
// config_loader_pkg
//   Shared constants for the configuration stream loader: default widths,
//   header opcodes, parser state encodings, error codes and the running
//   checksum fold used when CONFIG_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
package config_loader_pkg;

    localparam int DEF_DWIDTH = 32;
    localparam int DEF_AWIDTH = 16;
    localparam int DEF_LWIDTH = 12;

    // Header opcodes (header bits [31:28])
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_FILL  = 4'h2;
    localparam logic [3:0] OP_END   = 4'hF;

    // Parser states
    localparam logic [2:0] ST_HDR      = 3'd0;
    localparam logic [2:0] ST_DATA     = 3'd1;
    localparam logic [2:0] ST_FILL_LD  = 3'd2;
    localparam logic [2:0] ST_FILL_RUN = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;
    localparam logic [2:0] ST_CHK      = 3'd5;

    // Error codes reported on err_code
    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_OPCODE       = 3'd1;
    localparam logic [2:0] ERR_EARLY_LAST   = 3'd2;
    localparam logic [2:0] ERR_MISSING_LAST = 3'd3;
    localparam logic [2:0] ERR_TKEEP        = 3'd4;
    localparam logic [2:0] ERR_CHECKSUM     = 3'd5;

    // Running packet checksum: XOR of header and every data word.
    function automatic logic [DEF_DWIDTH-1:0] chk_fold(input logic [DEF_DWIDTH-1:0] acc,
                                                       input logic [DEF_DWIDTH-1:0] word);
        return acc ^ word;
    endfunction

endpackage

// File: rtl/config_loader_cfg_write_slot.sv
// -----------------------------------------------------------------------------
// config_loader_cfg_write_slot
//   Single-entry holding register for the cfg write port. A load captures
//   address/data and raises o_wen; the entry clears when i_wready accepts it.
//   o_ready allows a new load in the same cycle the held entry drains.
// Ports
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_load              capture i_addr/i_data (only when o_ready)
//   i_addr, i_data      write address / data to hold
//   i_wready            downstream accepts the held write
//   o_ready             slot can take a load this cycle
//   o_wen/o_waddr/o_wdata  registered cfg write request
// -----------------------------------------------------------------------------
module config_loader_cfg_write_slot #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_wready,
    output logic              o_ready,
    output logic              o_wen,
    output logic [AWIDTH-1:0] o_waddr,
    output logic [DWIDTH-1:0] o_wdata
);

    logic              r_wen;
    logic [AWIDTH-1:0] r_waddr;
    logic [DWIDTH-1:0] r_wdata;

    assign o_ready = !r_wen || i_wready;
    assign o_wen   = r_wen;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;

    // Hold one write request until the downstream handshake completes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (i_load) begin
            r_wen   <= 1'b1;
            r_waddr <= i_addr;
            r_wdata <= i_data;
        end else if (i_wready) begin
            r_wen   <= 1'b0;
        end
    end

endmodule

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//   Parses header-led packets from a 32-bit AXI-stream and issues register
//   writes on a single-entry cfg write port.
//   Header: [31:28] opcode (WRITE/FILL/END), [27:12] address, [11:0] len
//   (len+1 words).
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   s_axis_*              configuration stream (tkeep must be all-ones)
//   cfg_wen/waddr/wdata   write request, held until cfg_wready
//   cfg_wready            downstream write accept
//   busy                  parser is not waiting for a header
//   done                  one-cycle pulse on a well-formed END packet
//   err, err_code         one-cycle error pulse / last error code (held)
// Build option
//   CONFIG_CHECKSUM_EN    WRITE/FILL packets carry a trailing XOR checksum
//                         word which carries tlast instead of the last data word.
// -----------------------------------------------------------------------------
module config_loader
    import config_loader_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int LWIDTH = DEF_LWIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [DWIDTH-1:0]   s_axis_tdata,
    input  logic [DWIDTH/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    output logic                cfg_wen,
    output logic [AWIDTH-1:0]   cfg_waddr,
    output logic [DWIDTH-1:0]   cfg_wdata,
    input  logic                cfg_wready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2:0]          err_code
);

    logic [2:0]        r_state, w_state_nxt;
    logic [AWIDTH-1:0] r_addr, w_addr_nxt;
    logic [LWIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [DWIDTH-1:0] r_fill, w_fill_nxt;
    logic              r_busy, r_done, r_err;
    logic [2:0]        r_err_code;
    logic              w_done_nxt, w_err_nxt;
    logic [2:0]        w_code_nxt;
    logic              w_tready, w_acc, w_keep_ok, w_slot_ready, w_load;
    logic [DWIDTH-1:0] w_ld_data;
    logic [3:0]        w_op;
    logic [AWIDTH-1:0] w_hdr_addr;
    logic [LWIDTH-1:0] w_hdr_len;
`ifdef CONFIG_CHECKSUM_EN
    logic [DWIDTH-1:0] r_chk, w_chk_nxt;
    logic              r_is_fill, w_is_fill_nxt;
`endif

    assign w_op       = s_axis_tdata[DWIDTH-1 -: 4];
    assign w_hdr_addr = s_axis_tdata[LWIDTH +: AWIDTH];
    assign w_hdr_len  = s_axis_tdata[LWIDTH-1:0];
    assign w_keep_ok  = &s_axis_tkeep;
    assign w_acc      = s_axis_tvalid && w_tready;

    assign s_axis_tready = w_tready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign err_code      = r_err_code;

    // Stream ready per state; HDR waits for any pending cfg write to drain.
    always_comb begin
        w_tready = 1'b0;
        if (reset) begin
            w_tready = 1'b0;
        end else begin
            case (r_state)
                ST_HDR:      w_tready = !cfg_wen;
                ST_DATA:     w_tready = w_slot_ready;
                ST_FILL_LD:  w_tready = 1'b1;
                ST_DRAIN:    w_tready = 1'b1;
`ifdef CONFIG_CHECKSUM_EN
                ST_CHK:      w_tready = 1'b1;
`endif
                default:     w_tready = 1'b0;
            endcase
        end
    end

    // Packet parser: next state, address/count bookkeeping and status pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_fill_nxt  = r_fill;
        w_load      = 1'b0;
        w_ld_data   = s_axis_tdata;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_code_nxt  = r_err_code;
`ifdef CONFIG_CHECKSUM_EN
        w_chk_nxt     = r_chk;
        w_is_fill_nxt = r_is_fill;
`endif
        if (w_acc && !w_keep_ok) begin
            // A bad tkeep word is never written; resync on tlast.
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_TKEEP;
            w_state_nxt = s_axis_tlast ? ST_HDR : ST_DRAIN;
        end else begin
            case (r_state)
                ST_HDR: begin
                    if (w_acc) begin
                        w_addr_nxt = w_hdr_addr;
                        w_cnt_nxt  = w_hdr_len;
`ifdef CONFIG_CHECKSUM_EN
                        w_chk_nxt     = s_axis_tdata;
                        w_is_fill_nxt = (w_op == OP_FILL);
`endif
                        case (w_op)
                            OP_WRITE, OP_FILL: begin
                                if (s_axis_tlast) begin
                                    w_err_nxt  = 1'b1;
                                    w_code_nxt = ERR_EARLY_LAST;
                                end else begin
                                    w_state_nxt = (w_op == OP_WRITE) ? ST_DATA : ST_FILL_LD;
                                end
                            end
                            OP_END: begin
                                if (s_axis_tlast) begin
                                    w_done_nxt = 1'b1;
                                end else begin
                                    w_err_nxt   = 1'b1;
                                    w_code_nxt  = ERR_MISSING_LAST;
                                    w_state_nxt = ST_DRAIN;
                                end
                            end
                            default: begin
                                // Unknown opcode: drain the rest unless this word closes it.
                                w_err_nxt   = 1'b1;
                                w_code_nxt  = ERR_OPCODE;
                                w_state_nxt = s_axis_tlast ? ST_HDR : ST_DRAIN;
                            end
                        endcase
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_DATA: begin
                    if (w_acc) begin
                        w_load     = 1'b1;
                        w_addr_nxt = r_addr + AWIDTH'(1);
                        w_cnt_nxt  = r_cnt - LWIDTH'(1);
`ifdef CONFIG_CHECKSUM_EN
                        w_chk_nxt  = chk_fold(r_chk, s_axis_tdata);
                        if (s_axis_tlast) begin
                            w_err_nxt   = 1'b1;
                            w_code_nxt  = ERR_EARLY_LAST;
                            w_state_nxt = ST_HDR;
                        end else begin
                            w_state_nxt = (r_cnt == '0) ? ST_CHK : ST_DATA;
                        end
`else
                        if (r_cnt == '0) begin
                            if (s_axis_tlast) begin
                                w_state_nxt = ST_HDR;
                            end else begin
                                w_err_nxt   = 1'b1;
                                w_code_nxt  = ERR_MISSING_LAST;
                                w_state_nxt = ST_DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            w_err_nxt   = 1'b1;
                            w_code_nxt  = ERR_EARLY_LAST;
                            w_state_nxt = ST_HDR;
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
`endif
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_FILL_LD: begin
                    if (w_acc) begin
                        w_fill_nxt = s_axis_tdata;
`ifdef CONFIG_CHECKSUM_EN
                        w_chk_nxt  = chk_fold(r_chk, s_axis_tdata);
                        if (s_axis_tlast) begin
                            w_err_nxt   = 1'b1;
                            w_code_nxt  = ERR_EARLY_LAST;
                            w_state_nxt = ST_HDR;
                        end else begin
                            w_state_nxt = ST_CHK;
                        end
`else
                        if (s_axis_tlast) begin
                            w_state_nxt = ST_FILL_RUN;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_code_nxt  = ERR_MISSING_LAST;
                            w_state_nxt = ST_DRAIN;
                        end
`endif
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_FILL_RUN: begin
                    if (w_slot_ready) begin
                        w_load      = 1'b1;
                        w_ld_data   = r_fill;
                        w_addr_nxt  = r_addr + AWIDTH'(1);
                        w_cnt_nxt   = r_cnt - LWIDTH'(1);
                        w_state_nxt = (r_cnt == '0) ? ST_HDR : ST_FILL_RUN;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
`ifdef CONFIG_CHECKSUM_EN
                ST_CHK: begin
                    if (w_acc) begin
                        if (!s_axis_tlast) begin
                            w_err_nxt   = 1'b1;
                            w_code_nxt  = ERR_MISSING_LAST;
                            w_state_nxt = ST_DRAIN;
                        end else if (s_axis_tdata != r_chk) begin
                            w_err_nxt   = 1'b1;
                            w_code_nxt  = ERR_CHECKSUM;
                            w_state_nxt = ST_HDR;
                        end else begin
                            w_state_nxt = r_is_fill ? ST_FILL_RUN : ST_HDR;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
`endif
                ST_DRAIN: begin
                    w_state_nxt = (w_acc && s_axis_tlast) ? ST_HDR : ST_DRAIN;
                end
                default: begin
                    w_state_nxt = ST_HDR;
                end
            endcase
        end
    end

    // Parser state and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_HDR;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_fill     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
`ifdef CONFIG_CHECKSUM_EN
            r_chk      <= '0;
            r_is_fill  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fill     <= w_fill_nxt;
            r_busy     <= (w_state_nxt != ST_HDR);
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_code_nxt;
`ifdef CONFIG_CHECKSUM_EN
            r_chk      <= w_chk_nxt;
            r_is_fill  <= w_is_fill_nxt;
`endif
        end
    end

    config_loader_cfg_write_slot #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_slot (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_load   (w_load),
        .i_addr   (r_addr),
        .i_data   (w_ld_data),
        .i_wready (cfg_wready),
        .o_ready  (w_slot_ready),
        .o_wen    (cfg_wen),
        .o_waddr  (cfg_waddr),
        .o_wdata  (cfg_wdata)
    );

endmodule

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader
//   Directed bench for config_loader (default build, no checksum word).
// -----------------------------------------------------------------------------
module tb_config_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        cfg_wen;
    logic [15:0] cfg_waddr;
    logic [31:0] cfg_wdata;
    logic        cfg_wready;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int e0;
    int d0;

    logic [15:0] wq_a[$];
    logic [31:0] wq_d[$];
    logic [15:0] exp_a[$];
    logic [31:0] exp_d[$];

    config_loader dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .cfg_wen       (cfg_wen),
        .cfg_waddr     (cfg_waddr),
        .cfg_wdata     (cfg_wdata),
        .cfg_wready    (cfg_wready),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    // Observe cfg handshakes and status pulses mid-cycle.
    always @(negedge clk) begin
        if (!reset && cfg_wen && cfg_wready) begin
            wq_a.push_back(cfg_waddr);
            wq_d.push_back(cfg_wdata);
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [3:0] k);
        int n;
        n = 0;
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tkeep  = k;
        while (!s_axis_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, 32'(wq_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < wq_a.size(); i++) begin
            chk({tag, "_addr"}, {16'h0, wq_a[i]}, {16'h0, exp_a[i]});
            chk({tag, "_data"}, wq_d[i], exp_d[i]);
        end
        wq_a.delete(); wq_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    initial begin
        reset         = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'h0;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b0;
        cfg_wready    = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready",   32'(s_axis_tready), 32'd0);
        chk("rst_wen",      32'(cfg_wen),       32'd0);
        chk("rst_waddr",    32'(cfg_waddr),     32'd0);
        chk("rst_wdata",    cfg_wdata,          32'd0);
        chk("rst_busy",     32'(busy),          32'd0);
        chk("rst_done",     32'(done),          32'd0);
        chk("rst_err",      32'(err),           32'd0);
        chk("rst_err_code", 32'(err_code),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_tready", 32'(s_axis_tready), 32'd1);

        // WRITE addr 0x10 len 2 at full rate
        e0 = err_cnt;
        exp_a = '{16'h0010, 16'h0011, 16'h0012};
        exp_d = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        send(32'h1001_0002, 1'b0, 4'hF);
        chk("w1_busy", 32'(busy), 32'd1);
        send(32'hAAAA_0001, 1'b0, 4'hF);
        chk("w1_lat_wen",   32'(cfg_wen),   32'd1);
        chk("w1_lat_waddr", 32'(cfg_waddr), 32'h0010);
        chk("w1_lat_wdata", cfg_wdata,      32'hAAAA_0001);
        send(32'hBBBB_0002, 1'b0, 4'hF);
        send(32'hCCCC_0003, 1'b1, 4'hF);
        settle();
        check_writes("w1");
        chk("w1_no_err",   32'(err_cnt - e0), 32'd0);
        chk("w1_err_code", 32'(err_code),     32'd0);
        chk("w1_idle",     32'(busy),         32'd0);

        // Same packet with cfg_wready low after the first write
        exp_a = '{16'h0010, 16'h0011, 16'h0012};
        exp_d = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        send(32'h1001_0002, 1'b0, 4'hF);
        send(32'hAAAA_0001, 1'b0, 4'hF);
        cfg_wready = 1'b0;
        #1;
        chk("w2_stall_tready", 32'(s_axis_tready), 32'd0);
        @(negedge clk);
        chk("w2_stall_nowrite", 32'(wq_a.size()), 32'd0);
        fork
            begin
                send(32'hBBBB_0002, 1'b0, 4'hF);
                send(32'hCCCC_0003, 1'b1, 4'hF);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                cfg_wready = 1'b1;
            end
        join
        settle();
        check_writes("w2");

        // FILL addr 0xFFFE len 3 wraps the address
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        exp_d = '{32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
        send(32'h2FFF_E003, 1'b0, 4'hF);
        send(32'h5A5A_5A5A, 1'b1, 4'hF);
        chk("fill_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("fill_tready_low", 32'(s_axis_tready), 32'd0);
            @(posedge clk);
            #1;
        end
        settle();
        check_writes("fill");
        chk("fill_idle", 32'(busy), 32'd0);

        // WRITE len 3 with tlast on the second data word
        e0 = err_cnt;
        send(32'h1010_0003, 1'b0, 4'hF);
        send(32'h1111_1111, 1'b0, 4'hF);
        send(32'h2222_2222, 1'b1, 4'hF);
        chk("early_err_pulse", 32'(err),      32'd1);
        chk("early_err_code",  32'(err_code), 32'd2);
        chk("early_hdr",       32'(busy),     32'd0);
        settle();
        chk("early_err_once",  32'(err_cnt - e0), 32'd1);
        wq_a.delete(); wq_d.delete();
        exp_a = '{16'h0020};
        exp_d = '{32'h1234_5678};
        send(32'h1002_0000, 1'b0, 4'hF);
        send(32'h1234_5678, 1'b1, 4'hF);
        settle();
        check_writes("after_early");
        chk("early_code_held", 32'(err_code), 32'd2);

        // Unknown opcode: 5-word packet drained, then END
        e0 = err_cnt;
        d0 = done_cnt;
        send(32'h7000_0000, 1'b0, 4'hF);
        chk("op7_code",  32'(err_code), 32'd1);
        chk("op7_drain", 32'(busy),     32'd1);
        send(32'h0000_0001, 1'b0, 4'hF);
        send(32'h0000_0002, 1'b0, 4'hF);
        send(32'h0000_0003, 1'b0, 4'hF);
        send(32'h0000_0004, 1'b1, 4'hF);
        chk("op7_back_hdr", 32'(busy), 32'd0);
        send(32'hF000_0000, 1'b1, 4'hF);
        chk("end_done_pulse", 32'(done), 32'd1);
        settle();
        chk("op7_err_once", 32'(err_cnt - e0),  32'd1);
        chk("end_done_once", 32'(done_cnt - d0), 32'd1);
        check_writes("op7");

        // Bad tkeep on a data word carrying tlast
        e0 = err_cnt;
        send(32'h1005_0000, 1'b0, 4'hF);
        send(32'hDEAD_BEEF, 1'b1, 4'h7);
        chk("tkeep_code", 32'(err_code), 32'd4);
        chk("tkeep_hdr",  32'(busy),     32'd0);
        settle();
        chk("tkeep_err_once", 32'(err_cnt - e0), 32'd1);
        check_writes("tkeep");

        // Reset mid-DATA, then a fresh WRITE
        cfg_wready = 1'b0;
        send(32'h1003_0003, 1'b0, 4'hF);
        send(32'h3333_3333, 1'b0, 4'hF);
        chk("mid_wen",  32'(cfg_wen), 32'd1);
        chk("mid_busy", 32'(busy),    32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_wen",    32'(cfg_wen),       32'd0);
        chk("mid_rst_busy",   32'(busy),          32'd0);
        chk("mid_rst_tready", 32'(s_axis_tready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cfg_wready = 1'b1;
        exp_a = '{16'h0040, 16'h0041};
        exp_d = '{32'h4444_0000, 32'h4444_0001};
        send(32'h1004_0001, 1'b0, 4'hF);
        send(32'h4444_0000, 1'b0, 4'hF);
        send(32'h4444_0001, 1'b1, 4'hF);
        settle();
        check_writes("post_rst");

        chk("done_err_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
